// File: rtl/lab3_pio_pkg.sv
// lab3_pio_pkg -- shared constants for the lab3 parallel I/O block.
//
// Holds the word addresses of the register map and the encodings of the
// EDGE_TYPE parameter used by lab3_pio_gen2 and pio_sync_edge.
package lab3_pio_pkg;

  // Register map (word addresses). Addresses 6 and 7 are unused.
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  // EDGE_TYPE encodings.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge -- input synchroniser and per-bit edge pulse generator.
//
// Optional feature macro: PIO_EDGE_IRQ_EN. When it is defined, a prev
// flop stage and the edge_pulse output exist. When it is not defined,
// only the synchroniser is built.
//
// Ports:
//   clk         in   clock, all state on its rising edge
//   reset_n     in   asynchronous active-low reset
//   in_port     in   WIDTH asynchronous pin inputs
//   in_sync     out  WIDTH pins after SYNC_STAGES flops
//   edge_pulse  out  WIDTH one-cycle edge flags (PIO_EDGE_IRQ_EN only)
module pio_sync_edge
  import lab3_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync
`ifdef PIO_EDGE_IRQ_EN
  ,
  output logic [WIDTH-1:0] edge_pulse
`endif
);

  // sync_q[0] is the first (metastable-prone) stage; the last stage is in_sync.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] prev_q;

  // prev resets to 0 together with the synchroniser, so after reset an edge
  // is only seen once in_sync actually differs from prev.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= in_sync;
    end
  end

  always_comb begin
    edge_pulse = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_pulse = in_sync & ~prev_q;
      EDGE_FALL: edge_pulse = ~in_sync & prev_q;
      EDGE_ANY:  edge_pulse = in_sync ^ prev_q;
      default:   edge_pulse = '0;
    endcase
  end
`endif

endmodule

// File: rtl/lab3_pio_gen2.sv
// lab3_pio_gen2 -- memory-mapped parallel I/O port with optional edge
// capture interrupt.
//
// Optional feature macro: PIO_EDGE_IRQ_EN. Defined: IRQ_MASK, EDGE_CAP and
// irq are implemented. Undefined: irq is 0, addresses 2/3 read 0 and
// ignore writes.
//
// Ports:
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset
//   address     in   3-bit word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   32-bit write data (only [WIDTH-1:0] used)
//   readdata    out  32-bit read data, combinational from address
//   in_port     in   WIDTH asynchronous pin inputs
//   out_port    out  WIDTH data_out register
//   port_oe     out  WIDTH direction register, 1 = drive
//   irq         out  registered level interrupt
module lab3_pio_gen2
  import lab3_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int OUT_RESET   = 0,
  parameter int DIR_RESET   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] port_oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] OUT_RST_V = WIDTH'(OUT_RESET);
  localparam logic [WIDTH-1:0] DIR_RST_V = WIDTH'(DIR_RESET);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rd_word;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

`ifdef PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clr;
`endif

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .in_sync   (in_sync)
`ifdef PIO_EDGE_IRQ_EN
    ,
    .edge_pulse(edge_pulse)
`endif
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= OUT_RST_V;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   data_out <= wdata;
        ADDR_OUTSET: data_out <= data_out | wdata;
        ADDR_OUTCLR: data_out <= data_out & ~wdata;
        default:     data_out <= data_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q <= DIR_RST_V;
    end else if (wr_en && address == ADDR_DIR) begin
      dir_q <= wdata;
    end
  end

`ifdef PIO_EDGE_IRQ_EN
  assign cap_clr = (wr_en && address == ADDR_EDGE_CAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_en && address == ADDR_IRQ_MASK) begin
      irq_mask <= wdata;
    end
  end

  // Set is ORed in after the clear so a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_pulse;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irq_mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // DATA reads the pin for inputs and the output latch for driven bits.
  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:     rd_word = (in_sync & ~dir_q) | (data_out & dir_q);
      ADDR_DIR:      rd_word = dir_q;
`ifdef PIO_EDGE_IRQ_EN
      ADDR_IRQ_MASK: rd_word = irq_mask;
      ADDR_EDGE_CAP: rd_word = edge_cap;
`endif
      default:       rd_word = '0;
    endcase
  end

  assign readdata = 32'(rd_word);
  assign out_port = data_out;
  assign port_oe  = dir_q;

endmodule

// File: doc/lab3_pio_gen2.md
LAB3_PIO_GEN2 -- requirements
Module: lab3_pio_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 8: port width in bits, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge.
REQ-004 SHALL have parameter OUT_RESET, default 0: data_out value after reset.
REQ-005 SHALL have parameter DIR_RESET, default 0: direction register value after reset.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port address, input, 3 bits: word address.
REQ-009 SHALL have port chipselect, input, 1 bit: slave select.
REQ-010 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-011 SHALL have port writedata, input, 32 bits: write data.
REQ-012 SHALL have port readdata, output, 32 bits: read data, combinational from address.
REQ-013 SHALL have port in_port, input, WIDTH bits: asynchronous pin inputs.
REQ-014 SHALL have port out_port, output, WIDTH bits: data_out register.
REQ-015 SHALL have port port_oe, output, WIDTH bits: direction register; 1 = drive.
REQ-016 SHALL have port irq, output, 1 bit: registered, level-sensitive interrupt.

Function
REQ-017 A write SHALL occur when chipselect=1 and write_n=0, taking effect on the next clk edge. Only writedata[WIDTH-1:0] is used.
REQ-018 The register map SHALL be:
- 0 DATA (RW). Read returns in_sync where dir=0 and data_out where dir=1. Write loads data_out.
- 1 DIR (RW).
- 2 IRQ_MASK (RW).
- 3 EDGE_CAP (read; write-1-to-clear).
- 4 OUTSET (write-only; ORs 1-bits into data_out).
- 5 OUTCLR (write-only; clears data_out bits written 1).
REQ-019 Reads of addresses 4 to 7 SHALL return 0, and writes to 6 or 7 SHALL be ignored. readdata bits [31:WIDTH] SHALL be 0.
REQ-020 in_port SHALL pass through SYNC_STAGES flops to form in_sync, plus one delay flop, prev, used for edge detection.
REQ-021 An edge (per EDGE_TYPE, comparing in_sync with prev) SHALL set its EDGE_CAP bit on the following clk edge. The capture bit SHALL be visible SYNC_STAGES+1 edges after in_port changes.
REQ-022 The edge-detect set SHALL win over a simultaneous write-1-to-clear of the same bit.
REQ-023 irq SHALL be |(EDGE_CAP & IRQ_MASK), registered, one edge after the capture bit or mask bit is set. It SHALL deassert one edge after the last qualifying bit is cleared.
REQ-024 Edge detection SHALL run regardless of DIR.

Reset
REQ-025 When reset_n=0, outputs and registers SHALL clear asynchronously: data_out=OUT_RESET, DIR=DIR_RESET, IRQ_MASK=0, EDGE_CAP=0, irq=0, synchroniser and prev flops=0.
REQ-026 Reset asserted mid-operation SHALL discard pending captures. No edge SHALL be reported on the first cycles after release unless in_sync differs from prev.

Configuration
REQ-027 With PIO_EDGE_IRQ_EN defined, the edge capture, mask and irq logic SHALL be present as specified.
REQ-028 Without PIO_EDGE_IRQ_EN, irq SHALL be tied 0, addresses 2 and 3 SHALL read 0 with writes ignored, and the prev flops SHALL be omitted.

Structure
REQ-029 Package lab3_pio_pkg SHALL hold the register address constants (ADDR_DATA to ADDR_OUTCLR) and the EDGE_RISE/EDGE_FALL/EDGE_ANY constants.
REQ-030 Sub-module pio_sync_edge SHALL hold the synchroniser, prev flops and per-bit edge pulse generation, parameterised by WIDTH, SYNC_STAGES and EDGE_TYPE.

Verification
REQ-031 Bench SHALL cover, at WIDTH=8:
- Reset then read each address → DATA=0, DIR=0, readdata[31:8]=0.
- Write DIR=0xFF and DATA=0xA5, then OUTSET=0x0A, then OUTCLR=0x21 → out_port=0xA5, then 0xAF, then 0x8E; DATA reads 0x8E.
- EDGE_TYPE=0, IRQ_MASK=0x01, in_port bit0 rises at edge k → EDGE_CAP=0x01 at edge k+3 and irq=1 at edge k+4. Writing EDGE_CAP=0x01 → irq=0 one edge later.
- Rising edge and write-1-to-clear on the same cycle → EDGE_CAP bit remains 1.
- DIR=0x0F, in_port=0x30, data_out=0x05 → DATA reads 0x35 after 2 edges.
- reset_n pulsed low with EDGE_CAP=0xFF and irq=1 → both 0 immediately, without a clock edge; build without PIO_EDGE_IRQ_EN → address 3 reads 0 and irq is stuck at 0.
